// File: rtl/bus_access_arbiter.sv
// Round-robin arbiter that shares one external memory port among the ITLB, ICache, DTLB and DCache.
// One access at a time: the winner is latched in Idle, held in Access until mem_done, and acknowledged in Done.
module bus_access_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 34,
    parameter int DATA_WIDTH = 128
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ-1:0]                     req_read,
    input  logic [N_REQ-1:0]                     req_write,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
    output logic [N_REQ-1:0]                     read_done,
    output logic [N_REQ-1:0]                     write_done,
    output logic [DATA_WIDTH-1:0]                read_value,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic                                 mem_enable,
    output logic                                 mem_is_write,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_done,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic [1:0]                           dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: req_read/req_write are levels held until the matching one-cycle
    // done pulse; mem_enable is held with stable address/data until mem_done.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_owner_q, last_owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic                    mem_enable_q, mem_enable_d;
    logic [DATA_WIDTH-1:0]   rvalue_q, rvalue_d;
    logic [N_REQ-1:0]        read_done_q, read_done_d;
    logic [N_REQ-1:0]        write_done_q, write_done_d;

    logic [N_REQ-1:0]        active;
    logic                    grant_found;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand_idx;
    int                      cand;

    // Search begins one past the previous owner and wraps, so every active
    // requester is reached within N_REQ arbitrations.
    always_comb begin
        active      = req_read | req_write;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_owner_q) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_found && active[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        mem_enable_d = mem_enable_q;
        rvalue_d     = rvalue_q;
        read_done_d  = '0;
        write_done_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d      = ST_ACCESS;
                    owner_d      = grant_idx;
                    last_owner_d = grant_idx;
                    addr_d       = req_addr[grant_idx];
                    wdata_d      = req_wdata[grant_idx];
                    // A pending write goes first so a dirty-line write-back precedes its refill.
                    is_write_d   = req_write[grant_idx];
                    mem_enable_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (mem_done) begin
                    state_d      = ST_DONE;
                    rvalue_d     = mem_rdata;
                    mem_enable_d = 1'b0;
                    if (is_write_q) begin
                        write_done_d[owner_q] = 1'b1;
                    end else begin
                        read_done_d[owner_q] = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                mem_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            mem_enable_q <= 1'b0;
            rvalue_q     <= '0;
            read_done_q  <= '0;
            write_done_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            mem_enable_q <= mem_enable_d;
            rvalue_q     <= rvalue_d;
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
        end
    end

    assign read_done    = read_done_q;
    assign write_done   = write_done_q;
    assign read_value   = rvalue_q;
    assign mem_addr     = addr_q;
    assign mem_enable   = mem_enable_q;
    assign mem_is_write = is_write_q;
    assign mem_wdata    = wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Bench for bus_access_arbiter: a latency-programmable memory responder, a done-pulse
// monitor checked against an expected-transaction queue, a vector table and corner sequences.
module tb_bus_access_arbiter;

    localparam int N_REQ = 4;
    localparam int AW    = 34;
    localparam int DW    = 128;
    localparam int W     = 4 + 1 + 1 + 2 + AW + DW;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0][AW-1:0]  req_addr;
    logic [N_REQ-1:0]          req_read;
    logic [N_REQ-1:0]          req_write;
    logic [N_REQ-1:0][DW-1:0]  req_wdata;
    logic [N_REQ-1:0]          read_done;
    logic [N_REQ-1:0]          write_done;
    logic [DW-1:0]             read_value;
    logic [AW-1:0]             mem_addr;
    logic                      mem_enable;
    logic                      mem_is_write;
    logic [DW-1:0]             mem_wdata;
    logic                      mem_done;
    logic [DW-1:0]             mem_rdata;
    logic [1:0]                dbg_state;

    logic                      resp_done;
    logic                      spur_done;
    int                        lat_cfg;
    logic                      use_fixed;
    logic [DW-1:0]             fixed_rdata;

    int                        checks = 0;
    int                        errors = 0;
    logic [W-1:0]              exp_q[$];

    typedef struct {
        logic [1:0]    idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
    } vec_t;
    vec_t vecs[6];

    assign mem_done = resp_done | spur_done;

    bus_access_arbiter #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr     (req_addr),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_wdata    (req_wdata),
        .read_done    (read_done),
        .write_done   (write_done),
        .read_value   (read_value),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_is_write (mem_is_write),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
        return {a[31:0], ~a[31:0], 32'h0123_4567, a[31:0] ^ 32'h89AB_CDEF};
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        return use_fixed ? fixed_rdata : rdata_fn(a);
    endfunction

    function automatic logic [W-1:0] mk(input int lat, input logic we, input logic [1:0] idx,
                                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {4'(lat), we, we, idx, a, d};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_enable"},   W'(mem_enable),   W'(0));
        check({tag, "_mem_is_write"}, W'(mem_is_write), W'(0));
        check({tag, "_mem_addr"},     W'(mem_addr),     W'(0));
        check({tag, "_mem_wdata"},    W'(mem_wdata),    W'(0));
        check({tag, "_read_done"},    W'(read_done),    W'(0));
        check({tag, "_write_done"},   W'(write_done),   W'(0));
        check({tag, "_read_value"},   W'(read_value),   W'(0));
        check({tag, "_state"},        W'(dbg_state),    W'(0));
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int en_seen;
        en_seen   = 0;
        resp_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_enable) begin
                en_seen++;
                if (en_seen == lat_cfg) begin
                    resp_done = 1'b1;
                    mem_rdata = exp_rdata(mem_addr);
                end else begin
                    resp_done = 1'b0;
                end
            end else begin
                en_seen   = 0;
                resp_done = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int            en_cnt;
        int            owner;
        logic [AW-1:0] cur_addr;
        logic          cur_we;
        logic [DW-1:0] cur_wdata;
        logic [N_REQ-1:0] dmask;
        logic [DW-1:0] data;
        en_cnt    = 0;
        cur_addr  = '0;
        cur_we    = 1'b0;
        cur_wdata = '0;
        forever begin
            @(negedge clk);
            dmask = read_done | write_done;
            if (mem_enable) begin
                if (en_cnt > 0) begin
                    check("mem_hold", W'({mem_addr, mem_is_write, mem_wdata}),
                          W'({cur_addr, cur_we, cur_wdata}));
                end
                cur_addr  = mem_addr;
                cur_we    = mem_is_write;
                cur_wdata = mem_wdata;
                en_cnt++;
            end
            if (dmask != '0) begin
                check("done_onehot", W'($countones({read_done, write_done})), W'(1));
                owner = 0;
                for (int i = 0; i < N_REQ; i++) begin
                    if (dmask[i[1:0]]) owner = i;
                end
                data = (|write_done) ? cur_wdata : read_value;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got rd=%b wr=%b expected none", read_done, write_done);
                end else begin
                    check("txn", {4'(en_cnt), cur_we, |write_done, 2'(owner), cur_addr, data},
                          exp_q.pop_front());
                end
                en_cnt = 0;
            end else if (!mem_enable) begin
                en_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input logic [1:0] idx, input logic we, input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (we ? write_done[idx] : read_done[idx]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done pulse expected one within 100 cycles", name);
        end
    endtask

    task automatic wait_enable(input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mem_enable) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_enable_timeout: got mem_enable=0 expected 1", name);
        end
    endtask

    task automatic do_access(input logic [1:0] idx, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input int lat, input string name);
        lat_cfg = lat;
        exp_q.push_back(mk(lat, we, idx, a, we ? wd : exp_rdata(a)));
        @(negedge clk);
        req_addr[idx]  = a;
        req_wdata[idx] = wd;
        if (we) req_write[idx] = 1'b1;
        else    req_read[idx]  = 1'b1;
        wait_done(idx, we, name);
        req_read[idx]  = 1'b0;
        req_write[idx] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        int served;
        logic raise0;
        logic [1:0] seen;

        rst         = 1'b1;
        req_addr    = '0;
        req_read    = '0;
        req_write   = '0;
        req_wdata   = '0;
        spur_done   = 1'b0;
        lat_cfg     = 1;
        use_fixed   = 1'b0;
        fixed_rdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

        vecs[0] = '{2'd0, 1'b0, 34'h0_0000_1000, 128'h0, 1};
        vecs[1] = '{2'd1, 1'b1, 34'h3_FFFF_FFF0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 2};
        vecs[2] = '{2'd2, 1'b0, 34'h1_2345_6780, 128'h0, 3};
        vecs[3] = '{2'd3, 1'b1, 34'h2_0000_0000, {4{32'hCAFE_F00D}}, 1};
        vecs[4] = '{2'd1, 1'b0, 34'h3_FFFF_FFFF, 128'h0, 15};
        vecs[5] = '{2'd0, 1'b1, 34'h0_0000_0000, {DW{1'b1}}, 5};

        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_access(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].lat, "vec");
        end

        use_fixed = 1'b1;
        do_access(2'd3, 1'b0, 34'h0_8000_0040, 128'h0, 4, "single_read");
        use_fixed = 1'b0;

        // round-robin: all four read continuously from reset, 0 re-requests once
        pulse_reset();
        lat_cfg = 2;
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i] = AW'(34'h100 * (i + 1));
        end
        for (int i = 0; i < N_REQ; i++) begin
            exp_q.push_back(mk(2, 1'b0, i[1:0], AW'(34'h100 * (i + 1)), rdata_fn(AW'(34'h100 * (i + 1)))));
        end
        exp_q.push_back(mk(2, 1'b0, 2'd0, 34'h100, rdata_fn(34'h100)));
        req_read = 4'hF;
        served   = 0;
        raise0   = 1'b0;
        for (int c = 0; c < 200 && served < 5; c++) begin
            @(negedge clk);
            if (raise0) begin
                req_read[0] = 1'b1;
                raise0      = 1'b0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (read_done[i[1:0]]) begin
                    req_read[i[1:0]] = 1'b0;
                    served++;
                    if (i == 0 && served == 1) raise0 = 1'b1;
                end
            end
        end
        checks++;
        if (served != 5) begin
            errors++;
            $display("FAIL rr_served: got %0d expected 5", served);
        end

        // write-before-read on one requester
        addr_a = 34'h2_AAAA_0000;
        addr_b = 34'h1_BBBB_0040;
        lat_cfg = 3;
        exp_q.push_back(mk(3, 1'b1, 2'd3, addr_a, {16{8'hAA}}));
        exp_q.push_back(mk(3, 1'b0, 2'd3, addr_b, rdata_fn(addr_b)));
        @(negedge clk);
        req_addr[3]  = addr_a;
        req_wdata[3] = {16{8'hAA}};
        req_write[3] = 1'b1;
        req_read[3]  = 1'b1;
        wait_done(2'd3, 1'b1, "wbr_write");
        req_write[3] = 1'b0;
        req_addr[3]  = addr_b;
        wait_done(2'd3, 1'b0, "wbr_read");
        req_read[3]  = 1'b0;

        // abandoned request still completes
        lat_cfg = 5;
        exp_q.push_back(mk(5, 1'b0, 2'd2, 34'h0_5555_0000, rdata_fn(34'h0_5555_0000)));
        @(negedge clk);
        req_addr[2] = 34'h0_5555_0000;
        req_read[2] = 1'b1;
        wait_enable("abandon");
        @(negedge clk);
        req_read[2] = 1'b0;
        wait_done(2'd2, 1'b0, "abandon");

        // spurious mem_done in Idle
        repeat (3) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("spur_state",  W'(dbg_state),  W'(0));
            check("spur_enable", W'(mem_enable), W'(0));
            check("spur_done",   W'({read_done, write_done}), W'(0));
            @(negedge clk);
        end

        // reset during an access by requester 0, then 0 and 1 compete
        lat_cfg = 15;
        @(negedge clk);
        req_addr[0] = 34'h0_0F00_0000;
        req_read[0] = 1'b1;
        wait_enable("rst_mid");
        @(negedge clk);
        rst         = 1'b1;
        req_read[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid");

        lat_cfg = 2;
        exp_q.push_back(mk(2, 1'b0, 2'd0, 34'h0_0000_0A00, rdata_fn(34'h0_0000_0A00)));
        exp_q.push_back(mk(2, 1'b0, 2'd1, 34'h0_0000_0B00, rdata_fn(34'h0_0000_0B00)));
        req_addr[0] = 34'h0_0000_0A00;
        req_addr[1] = 34'h0_0000_0B00;
        req_read[0] = 1'b1;
        req_read[1] = 1'b1;
        seen = 2'b00;
        for (int c = 0; c < 100 && seen != 2'b11; c++) begin
            @(negedge clk);
            if (read_done[0]) begin req_read[0] = 1'b0; seen[0] = 1'b1; end
            if (read_done[1]) begin req_read[1] = 1'b0; seen[1] = 1'b1; end
        end
        check("post_rst_both_served", W'(seen), W'(2'b11));

        repeat (5) @(negedge clk);
        check("exp_q_empty", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_access_arbiter.md
# bus_access_arbiter

- Shares the single external memory port among the four memory clients of the core: ITLB, ICache, DTLB and DCache.
- Selects one read or write request with round-robin priority and latches its address and data.
- Holds the memory request until the memory acknowledges it, then returns a one-cycle done pulse and the read data to the winning client.
- Sits between the cache/TLB request interfaces and the memory/bus adapter.

## Interface
- `N_REQ`, 4, number of requesters. Index 0 = ITLB, 1 = ICache, 2 = DTLB, 3 = DCache.
- `ADDR_WIDTH`, 34, physical address width (PADDR_WIDTH).
- `DATA_WIDTH`, 128, transfer width; equals the DCache line width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_addr` in N_REQ×ADDR_WIDTH: per-requester address.
- `req_read` in N_REQ: per-requester read request, level. Held until done.
- `req_write` in N_REQ: per-requester write request, level. Held until done.
- `req_wdata` in N_REQ×DATA_WIDTH: per-requester write data.
- `read_done` out N_REQ: one-cycle read-completion pulse to the owner.
- `write_done` out N_REQ: one-cycle write-completion pulse to the owner.
- `read_value` out DATA_WIDTH: latched read data, broadcast to all requesters. Valid while `read_done` is high.
- `mem_addr` out ADDR_WIDTH: address to memory.
- `mem_enable` out 1: memory access request.
- `mem_is_write` out 1: 1 = write access, 0 = read access.
- `mem_wdata` out DATA_WIDTH: write data to memory.
- `mem_done` in 1: memory completion, one-cycle pulse.
- `mem_rdata` in DATA_WIDTH: read data, valid with `mem_done`.

## Operation
- FSM states: Idle, Access, Done.
  - Idle: when any requester is active, pick a winner, latch its index, address, write data and direction, then go to Access. Otherwise stay in Idle.
  - Access: drive `mem_enable`=1 with the latched `mem_addr`, `mem_is_write` and `mem_wdata`, all stable. When `mem_done` is high, capture `mem_rdata` into the `read_value` register and go to Done.
  - Done: pulse `read_done[owner]` or `write_done[owner]` (selected by the latched direction), then go to Idle.
- Requester i is active when `req_read[i] | req_write[i]`.
- Winner selection is round-robin. Search starts at index `(last_owner+1) mod N_REQ`, wraps around, and takes the first active requester.
- `last_owner` updates only on the Idle→Access transition.
- If one requester asserts both read and write, the write is served first (dirty-line write-back before fill). The read stays pending and competes in a later arbitration.
- A requester that drops its request during Access does not abort it. The access completes and the done pulse is still issued.
- `mem_done` outside Access is ignored.
- At most one `read_done`/`write_done` bit is high in any cycle.
- In Idle and Done, `mem_enable`=0.
- `mem_addr`, `mem_is_write` and `mem_wdata` hold their last latched values outside Access.

## Timing
- Reset values:
  - state = Idle, `last_owner` = N_REQ-1, so index 0 has first priority.
  - `mem_enable`=0, `mem_is_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - `read_done`=0, `write_done`=0, `read_value`=0.
- Reset mid-Access: return to Idle next cycle with all outputs at reset values. Any in-flight memory transaction is dropped without a done pulse.
- A request that is active in cycle t while in Idle gives `mem_enable`=1 from cycle t+1.
- If `mem_done` arrives in cycle t+k (k≥1), the done pulse is in cycle t+k+1, and the next arbitration happens in cycle t+k+2.
- Minimum occupancy is 3 cycles per access (Idle, Access, Done).
- Requesters must deassert the served request on the clock edge after seeing their done pulse, so it is not re-arbitrated in the following Idle cycle.
- No combinational path from `req_*` or `mem_*` inputs to any output; all outputs are registered or driven from the FSM state.

## Test plan
- Single read:
  - Stimulus: `req_read[3]`=1 with addr 0x0_8000_0040; memory returns `mem_done` 4 cycles after `mem_enable`, with rdata 0x0123…EF.
  - Required: `mem_enable` high for exactly 4 cycles with `mem_is_write`=0; `read_done[3]` pulses 1 cycle with `read_value`=0x0123…EF; `write_done`=0.
- Round-robin:
  - Stimulus: all four requesters request reads continuously after reset.
  - Required: service order 0,1,2,3,0; each requester drops its request after its done pulse.
- Write-before-read:
  - Stimulus: requester 3 asserts `req_write` (wdata 0xAA…AA, addr A) and `req_read` (addr B) together.
  - Required: first access has `mem_is_write`=1, addr A, and ends with a `write_done[3]` pulse; the read of B is served in a later arbitration.
- Abandoned request:
  - Stimulus: requester 2 drops `req_read` 1 cycle into Access.
  - Required: `mem_enable` stays high until `mem_done`; `read_done[2]` still pulses.
- Spurious and late events:
  - Stimulus: `mem_done` pulsed while in Idle; later, `rst` asserted during Access.
  - Required: the spurious pulse causes no done pulse and no state change; after the reset cycle all outputs are 0 and the next arbitration grants index 0 first.
